// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two requester ports and the single-port data-memory port.
//   req0/req1, we0/we1, addr0/1, wdata0/1 : requester side, driven toward the arbiter
//   gnt0/1, done0/1, rdata0/1             : handshake and read results back to requesters
//   mem_addr, mem_wdata, mem_read, mem_load: memory command, driven by the arbiter
//   mem_rdata                             : memory read data, driven by the memory
// Modport slave is the arbiter's view; modport master is the requesters'/memory's view.
interface data_mem_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_load;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, done0, done1, rdata0, rdata1,
    output mem_addr, mem_wdata, mem_read, mem_load
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1,
    input  mem_addr, mem_wdata, mem_read, mem_load
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between port 0 (CPU MEM stage)
// and port 1 (debug/loader). Each accepted request is registered and run as exactly one
// memory transaction: IDLE -> ACCESS -> [WAIT x(RD_LAT-1), reads only] -> DONE -> IDLE.
//   clk   : rising-edge clock
//   clear : asynchronous active-low reset
//   bus   : requester handshake (req/we/addr/wdata in, gnt/done/rdata out) and memory port
module data_mem_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned RD_LAT = 1
) (
  input logic               clk,
  input logic               clear,
  data_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

  // Value of the wait counter in the final read cycle.
  localparam logic [1:0] LastWait = 2'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              capture;
  logic              active;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    capture  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          // On contention the port that did not own the last transaction wins.
          owner_d = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          we_d    = owner_d ? bus.we1 : bus.we0;
          addr_d  = owner_d ? bus.addr1 : bus.addr0;
          wdata_d = owner_d ? bus.wdata1 : bus.wdata0;
          last_d  = owner_d;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (we_q) begin
          state_d = StDone;
        end else if (RD_LAT <= 1) begin
          capture = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d   = 2'd1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == LastWait) begin
          capture = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (capture) begin
      if (owner_q) rdata1_d = bus.mem_rdata;
      else         rdata0_d = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Outputs decode straight from registered state so a reset drops them immediately.
  assign active        = (state_q == StAccess) || (state_q == StWait);
  assign bus.gnt0      = (state_q == StAccess) && !owner_q;
  assign bus.gnt1      = (state_q == StAccess) && owner_q;
  assign bus.done0     = (state_q == StDone) && !owner_q;
  assign bus.done1     = (state_q == StDone) && owner_q;
  assign bus.mem_addr  = active ? addr_q : '0;
  assign bus.mem_wdata = active ? wdata_q : '0;
  assign bus.mem_load  = (state_q == StAccess) && we_q;
  assign bus.mem_read  = active && !we_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  logic clk;
  logic clear;

  // Index [k] selects the instance (0: RD_LAT=1, 1: RD_LAT=3); [p] selects the port.
  logic [1:0]  req_v [2];
  logic [1:0]  we_v [2];
  logic [3:0]  addr_v [2][2];
  logic [15:0] wdata_v [2][2];
  logic [1:0]  gnt_v [2];
  logic [1:0]  done_v [2];
  logic [15:0] rdata_v [2][2];
  logic [1:0]  mem_load_v;
  logic [1:0]  mem_read_v;
  logic [3:0]  mem_addr_v [2];
  logic [15:0] mem_wdata_v [2];

  logic [15:0] mem_a [16];
  logic [15:0] mem_b [16];
  logic [1:0]  cnt_a, cnt_b;

  int vectors;
  int miscompares;

  // Reference model state
  logic [15:0] exp_mem [2][16];
  logic [15:0] exp_rdata [2][2];
  int          exp_last [2];

  data_mem_arbiter_if #(.DATA_W(16), .ADDR_W(4)) bus_a ();
  data_mem_arbiter_if #(.DATA_W(16), .ADDR_W(4)) bus_b ();

  data_mem_arbiter #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1)) dut_a (
    .clk   (clk),
    .clear (clear),
    .bus   (bus_a)
  );

  data_mem_arbiter #(.DATA_W(16), .ADDR_W(4), .RD_LAT(3)) dut_b (
    .clk   (clk),
    .clear (clear),
    .bus   (bus_b)
  );

  assign bus_a.req0   = req_v[0][0];
  assign bus_a.req1   = req_v[0][1];
  assign bus_a.we0    = we_v[0][0];
  assign bus_a.we1    = we_v[0][1];
  assign bus_a.addr0  = addr_v[0][0];
  assign bus_a.addr1  = addr_v[0][1];
  assign bus_a.wdata0 = wdata_v[0][0];
  assign bus_a.wdata1 = wdata_v[0][1];
  assign gnt_v[0]       = {bus_a.gnt1, bus_a.gnt0};
  assign done_v[0]      = {bus_a.done1, bus_a.done0};
  assign rdata_v[0][0]  = bus_a.rdata0;
  assign rdata_v[0][1]  = bus_a.rdata1;
  assign mem_load_v[0]  = bus_a.mem_load;
  assign mem_read_v[0]  = bus_a.mem_read;
  assign mem_addr_v[0]  = bus_a.mem_addr;
  assign mem_wdata_v[0] = bus_a.mem_wdata;

  assign bus_b.req0   = req_v[1][0];
  assign bus_b.req1   = req_v[1][1];
  assign bus_b.we0    = we_v[1][0];
  assign bus_b.we1    = we_v[1][1];
  assign bus_b.addr0  = addr_v[1][0];
  assign bus_b.addr1  = addr_v[1][1];
  assign bus_b.wdata0 = wdata_v[1][0];
  assign bus_b.wdata1 = wdata_v[1][1];
  assign gnt_v[1]       = {bus_b.gnt1, bus_b.gnt0};
  assign done_v[1]      = {bus_b.done1, bus_b.done0};
  assign rdata_v[1][0]  = bus_b.rdata0;
  assign rdata_v[1][1]  = bus_b.rdata1;
  assign mem_load_v[1]  = bus_b.mem_load;
  assign mem_read_v[1]  = bus_b.mem_read;
  assign mem_addr_v[1]  = bus_b.mem_addr;
  assign mem_wdata_v[1] = bus_b.mem_wdata;

  // Memories: data is only correct in the final read cycle, inverted before that.
  always_ff @(posedge clk) begin
    if (bus_a.mem_load) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
    cnt_a <= bus_a.mem_read ? cnt_a + 2'd1 : 2'd0;
  end
  assign bus_a.mem_rdata = (cnt_a == 2'd0) ? mem_a[bus_a.mem_addr] : ~mem_a[bus_a.mem_addr];

  always_ff @(posedge clk) begin
    if (bus_b.mem_load) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
    cnt_b <= bus_b.mem_read ? cnt_b + 2'd1 : 2'd0;
  end
  assign bus_b.mem_rdata = (cnt_b == 2'd2) ? mem_b[bus_b.mem_addr] : ~mem_b[bus_b.mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_val(input int k, input logic [3:0] a);
    return (k == 0) ? mem_a[a] : mem_b[a];
  endfunction

  // Round-robin rule: a lone requester wins; on contention the non-last-owner wins.
  function automatic int pick(input int k, input logic r0, input logic r1);
    int w;
    if (r0 && r1) w = (exp_last[k] == 0) ? 1 : 0;
    else          w = r1 ? 1 : 0;
    exp_last[k] = w;
    return w;
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      exp_last[k] = 1;
      exp_rdata[k][0] = '0;
      exp_rdata[k][1] = '0;
    end
  endtask

  // Walks one transaction from ACCESS through DONE plus the following IDLE cycle.
  task automatic txn_cycles(input int k, input int p, input logic w, input logic [3:0] a,
                            input logic [15:0] d, input bit drop, input bit pulse);
    int lat;
    int dc;
    logic [1:0]  eg, ed;
    logic        act, eld, erd;
    logic [3:0]  ea;
    logic [15:0] ewd;
    lat = (k == 0) ? 1 : 3;
    dc  = w ? 2 : 1 + lat;
    for (int c = 1; c <= dc + 1; c++) begin
      @(posedge clk);
      #1;
      eg  = (c == 1) ? 2'(1 << p) : 2'b00;
      ed  = (c == dc) ? 2'(1 << p) : 2'b00;
      act = (c <= (w ? 1 : lat));
      eld = (c == 1) && w;
      erd = act && !w;
      ea  = act ? a : 4'h0;
      ewd = act ? d : 16'h0;
      if (c == dc) begin
        if (w) exp_mem[k][a] = d;
        else   exp_rdata[k][p] = exp_mem[k][a];
      end
      chk($sformatf("ctl k%0d p%0d we%0d c%0d", k, p, w, c),
          {gnt_v[k], done_v[k], mem_load_v[k], mem_read_v[k], mem_addr_v[k], mem_wdata_v[k]},
          {eg, ed, eld, erd, ea, ewd});
      if (c >= dc) begin
        chk($sformatf("rdata0 k%0d c%0d", k, c), rdata_v[k][0], exp_rdata[k][0]);
        chk($sformatf("rdata1 k%0d c%0d", k, c), rdata_v[k][1], exp_rdata[k][1]);
      end
      if (c == dc && w) chk($sformatf("mem k%0d a%0d", k, a), mem_val(k, a), exp_mem[k][a]);
      if (c == 1 && drop)  req_v[k][p] = 1'b0;
      if (c == 1 && pulse) req_v[k][1-p] = 1'b1;
      if (c == 2 && pulse) req_v[k][1-p] = 1'b0;
    end
  endtask

  task automatic single(input int k, input int p, input logic w, input logic [3:0] a,
                        input logic [15:0] d, input bit pulse);
    int win;
    we_v[k][p]    = w;
    addr_v[k][p]  = a;
    wdata_v[k][p] = d;
    req_v[k][p]   = 1'b1;
    win = pick(k, req_v[k][0], req_v[k][1]);
    txn_cycles(k, win, w, a, d, 1'b1, pulse);
  endtask

  // Both ports hold req for n consecutive transactions, using the fields already set.
  task automatic run_both(input int k, input int n);
    int win;
    req_v[k] = 2'b11;
    for (int i = 0; i < n; i++) begin
      win = pick(k, 1'b1, 1'b1);
      txn_cycles(k, win, we_v[k][win], addr_v[k][win], wdata_v[k][win], 1'b0, 1'b0);
    end
    req_v[k] = 2'b00;
  endtask

  initial begin
    logic [15:0] old;
    int          k, n, mode;
    vectors = 0;
    miscompares = 0;
    clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_v[i] = 2'b00;
      we_v[i]  = 2'b00;
      for (int j = 0; j < 2; j++) begin
        addr_v[i][j]  = '0;
        wdata_v[i][j] = '0;
      end
    end
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset ctl k%0d", i),
          {gnt_v[i], done_v[i], mem_load_v[i], mem_read_v[i], mem_addr_v[i], mem_wdata_v[i]}, '0);
      chk($sformatf("reset rdata k%0d", i), {rdata_v[i][0], rdata_v[i][1]}, '0);
    end
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;

    // Fill both memories through random ports
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 16; a++)
        single(i, int'($urandom_range(0, 1)), 1'b1, 4'(a), 16'($urandom), 1'b0);

    // Directed write, then write/read of a known word
    single(0, 0, 1'b1, 4'd3, 16'h00AB, 1'b0);
    single(0, 0, 1'b1, 4'd5, 16'h1234, 1'b0);
    single(0, 1, 1'b0, 4'd5, 16'($urandom), 1'b0);
    chk("rdata1 is 1234", rdata_v[0][1], 16'h1234);
    chk("rdata0 still 0", rdata_v[0][0], 16'h0000);

    // Contention: both hold reads of addr 1 and 2
    we_v[0] = 2'b00;
    addr_v[0][0] = 4'd1;
    addr_v[0][1] = 4'd2;
    run_both(0, 4);

    // Long read latency instance
    single(1, 0, 1'b0, 4'd9, 16'($urandom), 1'b0);
    single(1, 1, 1'b0, 4'd4, 16'($urandom), 1'b0);
    we_v[1] = 2'b00;
    addr_v[1][0] = 4'd11;
    addr_v[1][1] = 4'd12;
    run_both(1, 3);

    // Early drop of req0, and a short req0 pulse while port 1 owns
    single(0, 0, 1'b0, 4'd3, 16'($urandom), 1'b0);
    single(0, 1, 1'b0, 4'd3, 16'($urandom), 1'b1);
    @(posedge clk);
    #1;
    chk("no gnt after pulse", {gnt_v[0], done_v[0]}, 4'b0000);

    // Reset in the ACCESS cycle of a write to addr 7
    old = exp_mem[0][7];
    we_v[0][0] = 1'b1;
    addr_v[0][0] = 4'd7;
    wdata_v[0][0] = ~old;
    req_v[0][0] = 1'b1;
    void'(pick(0, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    chk("clr pre load", {gnt_v[0], mem_load_v[0]}, {2'b01, 1'b1});
    #2 clear = 1'b0;
    #1;
    chk("clr async drop", {gnt_v[0], done_v[0], mem_load_v[0], mem_read_v[0]}, '0);
    req_v[0][0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    reset_model();
    chk("clr mem7 kept", mem_val(0, 4'd7), old);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("clr no done %0d", i), {gnt_v[0], done_v[0], mem_load_v[0]}, '0);
      chk($sformatf("clr rdata %0d", i), {rdata_v[0][0], rdata_v[0][1]}, '0);
    end
    we_v[0] = 2'b00;
    addr_v[0][0] = 4'd7;
    addr_v[0][1] = 4'd8;
    run_both(0, 2);

    // Randomised mix
    for (int it = 0; it < 30; it++) begin
      k = int'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 3));
      if (mode == 0) begin
        n = int'($urandom_range(2, 4));
        for (int p = 0; p < 2; p++) begin
          we_v[k][p]    = 1'($urandom);
          addr_v[k][p]  = 4'($urandom);
          wdata_v[k][p] = 16'($urandom);
        end
        run_both(k, n);
      end else begin
        single(k, int'($urandom_range(0, 1)), 1'($urandom), 4'($urandom), 16'($urandom),
               1'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
